// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use and memory-wait stalls,
// branch flushes, a data-memory timeout FSM and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic        dmem_req_M,
   input  logic        dmem_ready,
   input  logic        cnt_clr,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        err,
   output logic [1:0]  fsm_state,
   output logic [7:0]  wait_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      WAIT  = 2'd1,
      ERROR = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt_nxt;
   logic       err_nxt;
   logic       lw_stall;
   logic       mem_stall;
   logic       mem_busy;

   // Memory handshake: dmem_req_M is a request held in M; dmem_ready high in the
   // same cycle completes it. Request without ready means the whole pipe holds.
   assign mem_busy  = dmem_req_M & ~dmem_ready;
   assign mem_stall = mem_busy | (state == ERROR);
   assign lw_stall  = (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                      ((RdE == Rs1D) | (RdE == Rs2D));

   assign fsm_state = state;

   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
         ForwardAE = 2'b01;
   end

   always_comb begin
      ForwardBE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
         ForwardBE = 2'b01;
   end

   // Priority: memory stall freezes everything, then branch flush, then load-use.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      err_nxt      = err;
      case (state)
         RUN: begin
            if (mem_busy) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         WAIT: begin
            if (dmem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == TIMEOUT_CNT) begin
               state_nxt = ERROR;
               err_nxt   = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         ERROR: begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         err      <= err_nxt;
      end
   end

   // Clear wins over increment; both counters stick at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else if (cnt_clr) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (StallF && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (FlushD && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush, memory
// wait, timeout/error recovery and counter saturation/clear.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        RegWriteM, RegWriteW;
   logic [1:0]  ResultSrcE;
   logic        PCSrcE, dmem_req_M, dmem_ready, cnt_clr;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [15:0] stall_cnt, flush_cnt;
   logic        err;
   logic [1:0]  fsm_state;
   logic [7:0]  wait_cnt;
   logic [5:0]  ctrl;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_ERROR = 2'd2;

   // ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE}
   localparam logic [31:0] C_NONE   = 32'h00;
   localparam logic [31:0] C_MEM    = 32'h3C;
   localparam logic [31:0] C_LOAD   = 32'h31;
   localparam logic [31:0] C_BRANCH = 32'h03;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

   hazard_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err),
      .fsm_state(fsm_state), .wait_cnt(wait_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic idle();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
      PCSrcE = 1'b0; dmem_req_M = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_use(input logic on);
      ResultSrcE = on ? 2'b01 : 2'b00;
      RdE        = on ? 5'd3 : 5'd0;
      Rs2D       = on ? 5'd3 : 5'd0;
   endtask

   // scoreboard
   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, e);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      // reset state
      #12;
      push(32'(S_RUN)); push(32'h0); push(32'h0); push(32'h0); push(C_NONE);
      check("rst_state", 32'(fsm_state));
      check("rst_stall_cnt", 32'(stall_cnt));
      check("rst_flush_cnt", 32'(flush_cnt));
      check("rst_err", 32'(err));
      check("rst_ctrl", 32'(ctrl));
      @(negedge clk);
      rst = 1'b1;

      // forwarding
      RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
      Rs1E = 5'd5; Rs2E = 5'd0;
      push(32'h2); push(32'h0);
      #1;
      check("fwdA_mem", 32'(ForwardAE));
      check("fwdB_zero", 32'(ForwardBE));
      RdM = 5'd0;
      push(32'h1);
      #1;
      check("fwdA_wb", 32'(ForwardAE));
      RdM = 5'd7; Rs2E = 5'd7; RegWriteW = 1'b0;
      push(32'h2); push(32'h0);
      #1;
      check("fwdB_mem", 32'(ForwardBE));
      check("fwdA_none", 32'(ForwardAE));
      RegWriteM = 1'b0;
      push(32'h0);
      #1;
      check("fwdB_nowrite", 32'(ForwardBE));
      idle();

      // load-use stall, then branch overriding it
      tick();
      load_use(1'b1);
      push(C_LOAD);
      #1;
      check("lw_ctrl", 32'(ctrl));
      tick();
      idle();
      push(32'h1); push(C_NONE);
      #1;
      check("lw_stall_cnt", 32'(stall_cnt));
      check("lw_release", 32'(ctrl));
      load_use(1'b1);
      PCSrcE = 1'b1;
      push(C_BRANCH);
      #1;
      check("br_over_lw", 32'(ctrl));
      tick();
      idle();
      push(32'h1); push(32'h1);
      #1;
      check("br_flush_cnt", 32'(flush_cnt));
      check("br_stall_cnt", 32'(stall_cnt));
      ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
      push(C_NONE);
      #1;
      check("lw_rd0", 32'(ctrl));
      idle();

      // counter clear
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      push(32'h0); push(32'h0);
      #1;
      check("clr_stall_cnt", 32'(stall_cnt));
      check("clr_flush_cnt", 32'(flush_cnt));

      // memory wait: three waiting cycles, branch/load ignored meanwhile
      dmem_req_M = 1'b1; dmem_ready = 1'b0;
      push(C_MEM); push(32'(S_RUN));
      #1;
      check("mw1_ctrl", 32'(ctrl));
      check("mw1_state", 32'(fsm_state));
      tick();
      PCSrcE = 1'b1; load_use(1'b1);
      push(C_MEM); push(32'(S_WAIT)); push(32'h1);
      #1;
      check("mw2_ctrl", 32'(ctrl));
      check("mw2_state", 32'(fsm_state));
      check("mw2_wait_cnt", 32'(wait_cnt));
      tick();
      PCSrcE = 1'b0; load_use(1'b0);
      push(C_MEM); push(32'h2);
      #1;
      check("mw3_ctrl", 32'(ctrl));
      check("mw3_wait_cnt", 32'(wait_cnt));
      tick();
      dmem_ready = 1'b1;
      push(C_NONE); push(32'h3); push(32'(S_WAIT));
      #1;
      check("mw_ready_ctrl", 32'(ctrl));
      check("mw_stall_cnt", 32'(stall_cnt));
      check("mw4_state", 32'(fsm_state));
      tick();
      idle();
      push(32'(S_RUN)); push(32'h0); push(32'h3); push(32'h0);
      #1;
      check("mw_back_run", 32'(fsm_state));
      check("mw_wait_cnt0", 32'(wait_cnt));
      check("mw_stall_cnt_end", 32'(stall_cnt));
      check("mw_flush_cnt_end", 32'(flush_cnt));

      // timeout into ERROR, then reset recovery
      dmem_req_M = 1'b1; dmem_ready = 1'b0;
      repeat (4) tick();
      push(32'(S_WAIT)); push(32'h4); push(32'h0);
      #1;
      check("to_wait4_state", 32'(fsm_state));
      check("to_wait4_cnt", 32'(wait_cnt));
      check("to_wait4_err", 32'(err));
      tick();
      push(32'(S_ERROR)); push(32'h1);
      #1;
      check("to_error_state", 32'(fsm_state));
      check("to_error_err", 32'(err));
      dmem_req_M = 1'b0; dmem_ready = 1'b1; PCSrcE = 1'b1;
      push(C_MEM);
      #1;
      check("err_stuck_ctrl", 32'(ctrl));
      tick();
      push(32'(S_ERROR)); push(32'h1); push(C_MEM);
      #1;
      check("err_absorb_state", 32'(fsm_state));
      check("err_sticky", 32'(err));
      check("err_stuck_ctrl2", 32'(ctrl));
      PCSrcE = 1'b0;
      rst = 1'b0;
      push(32'(S_RUN)); push(32'h0); push(32'h0); push(32'h0); push(C_NONE);
      #1;
      check("async_rst_state", 32'(fsm_state));
      check("async_rst_err", 32'(err));
      check("async_rst_wait_cnt", 32'(wait_cnt));
      check("async_rst_stall_cnt", 32'(stall_cnt));
      check("async_rst_ctrl", 32'(ctrl));
      load_use(1'b1);
      push(C_LOAD);
      #1;
      check("rst_comb_track", 32'(ctrl));
      @(negedge clk);
      rst = 1'b1;
      idle();

      // stall counter saturation and clear-over-increment
      load_use(1'b1);
      repeat (65535) @(posedge clk);
      @(negedge clk);
      push(32'hFFFF);
      #1;
      check("sat_reach", 32'(stall_cnt));
      repeat (3) tick();
      push(32'hFFFF);
      #1;
      check("sat_hold", 32'(stall_cnt));
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      push(32'h0); push(C_LOAD);
      #1;
      check("clr_over_stall", 32'(stall_cnt));
      check("clr_ctrl", 32'(ctrl));
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum data-memory wait cycles before the error state.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have ports Rs1D and Rs2D, input, 5 each, the decode-stage source registers.
REQ-005 SHALL have ports Rs1E and Rs2E, input, 5 each, the execute-stage source registers.
REQ-006 SHALL have ports RdE, RdM and RdW, input, 5 each, the destination registers in E, M and W.
REQ-007 SHALL have ports RegWriteM and RegWriteW, input, 1 each, the writeback enables in M and W.
REQ-008 SHALL have port ResultSrcE, input, 2; value 2'b01 marks a load in E.
REQ-009 SHALL have port PCSrcE, input, 1, meaning a taken branch or jump is resolved in E.
REQ-010 SHALL have ports dmem_req_M, input, 1 (data-memory access in M) and dmem_ready, input, 1 (memory completes this cycle).
REQ-011 SHALL have port cnt_clr, input, 1, a synchronous clear of the performance counters.
REQ-012 SHALL have ports ForwardAE and ForwardBE, output, 2 each, the E-stage operand mux selects.
REQ-013 SHALL have ports StallF, StallD, StallE and StallM, output, 1 each, the stage hold enables.
REQ-014 SHALL have ports FlushD and FlushE, output, 1 each, which bubble the D and E pipeline registers.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, 16 each, and err, output, 1, a sticky timeout flag.

Function
REQ-016 SHALL drive ForwardAE combinationally as follows:
- 2'b10 if RegWriteM, RdM!=0 and RdM==Rs1E;
- else 2'b01 if RegWriteW, RdW!=0 and RdW==Rs1E;
- else 2'b00.
ForwardBE SHALL follow the same rule using Rs2E.
REQ-017 SHALL compute lwStall = (ResultSrcE==2'b01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-018 SHALL compute memStall = dmem_req_M & ~dmem_ready, or 1 whenever the state is ERROR.
REQ-019 SHALL give memStall top priority:
- StallF = StallD = StallE = StallM = 1;
- FlushD = FlushE = 0;
- PCSrcE and lwStall are ignored that cycle.
REQ-020 SHALL, when memStall=0 and PCSrcE=1, drive FlushD = FlushE = 1 and all stalls 0; a branch overrides lwStall.
REQ-021 SHALL, when memStall=0, PCSrcE=0 and lwStall=1, drive StallF = StallD = 1, FlushE = 1, StallE = StallM = 0 and FlushD = 0.
REQ-022 SHALL otherwise drive all stall and flush outputs 0.
REQ-023 SHALL implement an FSM with states RUN, WAIT and ERROR and an 8-bit wait_cnt.
REQ-024 SHALL move RUN->WAIT when dmem_req_M & ~dmem_ready, setting wait_cnt=1.
REQ-025 SHALL, in WAIT:
- return to RUN with wait_cnt=0 if dmem_ready=1;
- else move to ERROR if wait_cnt==TIMEOUT;
- else increment wait_cnt.
REQ-026 SHALL make ERROR absorbing until reset, with err=1 registered on entry.
REQ-027 SHALL increment stall_cnt each cycle StallF=1 and flush_cnt each cycle FlushD=1, both saturating at 16'hFFFF.
REQ-028 SHALL let cnt_clr=1 zero both counters on the next edge, taking priority over an increment in the same cycle.
REQ-029 SHALL keep all stall, flush and forward outputs purely combinational, with zero-cycle latency from their inputs.

Reset
REQ-030 SHALL, while rst=0, force state RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0 and err=0 immediately, independent of clk.
REQ-031 SHALL let combinational outputs track their inputs during reset, with the state taken as RUN.
REQ-032 SHALL make reset asserted mid-WAIT or in ERROR return the block to RUN with err=0.

Verification
REQ-033 SHALL cover forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10; with RdM=0 instead -> ForwardAE=01; with Rs2E=0 -> ForwardBE=00.
REQ-034 SHALL cover load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle and stall_cnt +1; the same with PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-035 SHALL cover memory wait: dmem_req_M=1, dmem_ready=0 for 3 cycles then 1 -> all four stalls high for 3 cycles, state WAIT then RUN, stall_cnt=3.
REQ-036 SHALL cover timeout: TIMEOUT=4, dmem_ready held 0 -> ERROR after the 5th waiting cycle, then err=1 and stalls stuck high after dmem_ready rises; rst low -> err=0, state RUN.
REQ-037 SHALL cover counters: stall_cnt preloaded to FFFF by sustained stall -> stays FFFF; cnt_clr with a stall in the same cycle -> 0.
